// File: rtl/status_writeback_unit_pkg.sv
// status_writeback_unit_pkg
//   Shared constants and helpers for the rstatus ($r30) writeback path:
//   opcode/ALU-op encodings, status codes, the rstatus register index,
//   the FIFO occupancy state type and the overflow/setx event decoder.
package status_writeback_unit_pkg;

  // Instruction opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  // R-type ALU opcodes that can raise an overflow
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Exception codes written into rstatus (already zero-extended)
  localparam logic [31:0] ST_ADD  = 32'd1;
  localparam logic [31:0] ST_ADDI = 32'd2;
  localparam logic [31:0] ST_SUB  = 32'd3;
  localparam logic [31:0] ST_MUL  = 32'd4;
  localparam logic [31:0] ST_DIV  = 32'd5;

  // Architectural register that holds rstatus
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  // Pending-write FIFO occupancy
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // One decoded rstatus event
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
  } status_evt_t;

  // setx always produces an event; arithmetic ops only when they overflowed.
  function automatic status_evt_t decode_event(input logic        valid,
                                               input logic [4:0]  op,
                                               input logic [4:0]  aluop,
                                               input logic        ovf,
                                               input logic [26:0] target);
    status_evt_t e;
    e = '0;
    if (valid) begin
      if (op == OP_SETX) begin
        e.valid = 1'b1;
        e.value = {5'b0, target};
      end else if (ovf) begin
        if (op == OP_ADDI) begin
          e.valid = 1'b1;
          e.value = ST_ADDI;
        end else if (op == OP_RTYPE) begin
          case (aluop)
            ALU_ADD: begin e.valid = 1'b1; e.value = ST_ADD; end
            ALU_SUB: begin e.valid = 1'b1; e.value = ST_SUB; end
            ALU_MUL: begin e.valid = 1'b1; e.value = ST_MUL; end
            ALU_DIV: begin e.valid = 1'b1; e.value = ST_DIV; end
            default: e = '0;
          endcase
        end
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/status_writeback_unit_fifo.sv
// status_fifo
//   DEPTH x DATA_W FIFO for pending $r30 writes, with an explicit
//   EMPTY/PARTIAL/FULL occupancy state machine.
// Ports:
//   clock, reset       rising-edge clock, async active-low reset
//   push, push_data    write an entry (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   head_data          current head entry
//   count              number of stored entries
//   full, empty        occupancy flags, decoded from the state register
module status_fifo
  import status_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  occ_e                         occ_q;
  logic                         do_push, do_pop;

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == OCC_EMPTY);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy FSM; full/empty come straight off this register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (do_push) occ_q <= OCC_PARTIAL;
        end
        OCC_PARTIAL: begin
          if (do_push && !do_pop && count_q == CNT_W'(DEPTH - 1))
            occ_q <= OCC_FULL;
          else if (do_pop && !do_push && count_q == CNT_W'(1))
            occ_q <= OCC_EMPTY;
        end
        OCC_FULL: begin
          if (do_pop) occ_q <= OCC_PARTIAL;
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/status_writeback_unit.sv
// status_writeback_unit
//   Decodes overflow / setx events from the execute stage, keeps the
//   architectural rstatus copy, queues $r30 writes toward the regfile
//   write-port arbiter and answers bex.
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   ex_valid/op/aluop/ovf/target execute-stage instruction fields
//   stall                        hold the execute stage (event but FIFO full)
//   wb_req/addr/data, wb_ack     $r30 write handshake toward the arbiter
//   bex_taken                    rstatus_q is non-zero
//   rstatus_q                    architectural rstatus
module status_writeback_unit
  import status_writeback_unit_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         DEPTH       = 2,
  parameter logic [4:0] RSTATUS_REG = status_writeback_unit_pkg::RSTATUS_REG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [4:0]        ex_op,
  input  logic [4:0]        ex_aluop,
  input  logic              ex_ovf,
  input  logic [26:0]       ex_target,
  output logic              stall,
  output logic              wb_req,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  output logic              bex_taken,
  output logic [DATA_W-1:0] rstatus_q
);

  status_evt_t          evt;
  logic [DATA_W-1:0]    ev_val;
  logic [DATA_W-1:0]    rstatus_d;
  logic                 push, pop;
  logic [DATA_W-1:0]    head_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 fifo_full, fifo_empty;

  assign evt    = decode_event(ex_valid, ex_op, ex_aluop, ex_ovf, ex_target);
  assign ev_val = DATA_W'(evt.value);

  // Stall comes from the registered full flag only, so a pop in the same
  // cycle does not release it; the held event pushes one cycle later.
  assign stall  = evt.valid & fifo_full;
  assign push   = evt.valid & ~fifo_full;
  assign pop    = wb_ack & ~fifo_empty;

  assign wb_req    = (fifo_count != '0);
  assign wb_addr   = RSTATUS_REG;
  assign wb_data   = fifo_empty ? '0 : head_data;
  assign bex_taken = |rstatus_q;

  // rstatus follows whatever is pushed, so it tracks the newest event.
  always_comb begin
    rstatus_d = rstatus_q;
    if (push) rstatus_d = ev_val;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rstatus_q <= '0;
    else        rstatus_q <= rstatus_d;
  end

  status_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (ev_val),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_status_writeback_unit.sv
// tb_status_writeback_unit
//   Scenario tasks drive the execute-stage and ack inputs. Each expected
//   $r30 write is queued in a scoreboard when its event is driven and is
//   popped and compared when the DUT offers it with wb_ack high.
module tb_status_writeback_unit;

  logic        clock, reset;
  logic        ex_valid, ex_ovf, wb_ack;
  logic [4:0]  ex_op, ex_aluop;
  logic [26:0] ex_target;
  logic        stall, wb_req, bex_taken;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, rstatus_q;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  status_writeback_unit #(.DATA_W(32), .DEPTH(2), .RSTATUS_REG(5'd30)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_aluop(ex_aluop), .ex_ovf(ex_ovf), .ex_target(ex_target),
    .stall(stall), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ack(wb_ack), .bex_taken(bex_taken), .rstatus_q(rstatus_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] alu,
                       input logic ovf, input logic [26:0] t);
    ex_valid = v; ex_op = op; ex_aluop = alu; ex_ovf = ovf; ex_target = t;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_ack = 1'b0;
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    repeat (2) tick();
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL reset_wb_req got %b want 0", wb_req); end
    n_cmp++; if (rstatus_q !== 32'd0) begin n_err++; $display("FAIL reset_rstatus got %h want 0", rstatus_q); end
    n_cmp++; if (bex_taken !== 1'b0) begin n_err++; $display("FAIL reset_bex got %b want 0", bex_taken); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    n_cmp++; if (wb_addr !== 5'd30) begin n_err++; $display("FAIL reset_wb_addr got %0d want 30", wb_addr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_no_event();
    drive(1, 5'b00000, 5'b00000, 0, 27'd0);   // add, no overflow
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL noev_stall got %b want 0", stall); end
    tick();
    drive(1, 5'b00000, 5'b00010, 1, 27'd0);   // and, flag set but not an overflow op
    tick();
    drive(0, 5'b00000, 5'b00001, 1, 27'd0);   // sub overflow but not valid
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL noev_wb_req got %b want 0", wb_req); end
    n_cmp++; if (rstatus_q !== 32'd0) begin n_err++; $display("FAIL noev_rstatus got %h want 0", rstatus_q); end
  endtask

  task automatic test_add_ovf();
    wb_ack = 1'b0;
    drive(1, 5'b00000, 5'b00000, 1, 27'd0);
    sb.push_back(32'd1);
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    n_cmp++; if (rstatus_q !== 32'd1) begin n_err++; $display("FAIL add_rstatus got %h want 1", rstatus_q); end
    n_cmp++; if (bex_taken !== 1'b1) begin n_err++; $display("FAIL add_bex got %b want 1", bex_taken); end
    n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL add_wb_req got %b want 1", wb_req); end
    n_cmp++; if (wb_addr !== 5'd30) begin n_err++; $display("FAIL add_wb_addr got %0d want 30", wb_addr); end
    wb_ack = 1'b1;
    #1;
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL add_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL add_wb_data got %h want %h", wb_data, exp_v); end end
    tick();
    wb_ack = 1'b0;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL add_drained got %b want 0", wb_req); end
    n_cmp++; if (rstatus_q !== 32'd1) begin n_err++; $display("FAIL add_rs_hold got %h want 1", rstatus_q); end
  endtask

  task automatic test_stall();
    wb_ack = 1'b0;
    drive(1, 5'b00101, 5'd0, 1, 27'd0);       // addi overflow
    sb.push_back(32'd2);
    tick();
    n_cmp++; if (rstatus_q !== 32'd2) begin n_err++; $display("FAIL st_rs_addi got %h want 2", rstatus_q); end
    drive(1, 5'b00000, 5'b00001, 1, 27'd0);   // sub overflow
    sb.push_back(32'd3);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_stall_sub got %b want 0", stall); end
    tick();
    n_cmp++; if (rstatus_q !== 32'd3) begin n_err++; $display("FAIL st_rs_sub got %h want 3", rstatus_q); end
    drive(1, 5'b00000, 5'b00111, 1, 27'd0);   // div overflow, FIFO full
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall_div got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall_held got %b want 1", stall); end
    n_cmp++; if (rstatus_q !== 32'd3) begin n_err++; $display("FAIL st_rs_frozen got %h want 3", rstatus_q); end
    wb_ack = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall_pop got %b want 1", stall); end
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL st_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL st_wb_data0 got %h want %h", wb_data, exp_v); end end
    tick();
    wb_ack = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_stall_rel got %b want 0", stall); end
    sb.push_back(32'd5);
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    n_cmp++; if (rstatus_q !== 32'd5) begin n_err++; $display("FAIL st_rs_div got %h want 5", rstatus_q); end
    wb_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (sb.size() == 0) begin n_err++; $display("FAIL st_sb_empty got %h want none", wb_data); end
      else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL st_drain%0d got %h want %h", i, wb_data, exp_v); end end
      tick();
    end
    wb_ack = 1'b0;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL st_drained got %b want 0", wb_req); end
  endtask

  task automatic test_setx();
    wb_ack = 1'b1;
    drive(1, 5'b10101, 5'd0, 0, 27'h1234);
    sb.push_back(32'h1234);
    tick();
    n_cmp++; if (bex_taken !== 1'b1) begin n_err++; $display("FAIL setx_bex1 got %b want 1", bex_taken); end
    n_cmp++; if (rstatus_q !== 32'h1234) begin n_err++; $display("FAIL setx_rs got %h want 1234", rstatus_q); end
    drive(1, 5'b10101, 5'd0, 1, 27'd0);
    sb.push_back(32'd0);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL setx_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL setx_wb0 got %h want %h", wb_data, exp_v); end end
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    n_cmp++; if (bex_taken !== 1'b0) begin n_err++; $display("FAIL setx_bex0 got %b want 0", bex_taken); end
    n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL setx_req got %b want 1", wb_req); end
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL setx_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL setx_wb1 got %h want %h", wb_data, exp_v); end end
    tick();
    wb_ack = 1'b0;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL setx_drained got %b want 0", wb_req); end
  endtask

  task automatic test_push_pop();
    wb_ack = 1'b0;
    drive(1, 5'b00000, 5'b00000, 1, 27'd0);
    sb.push_back(32'd1);
    tick();
    drive(1, 5'b00000, 5'b00110, 1, 27'd0);   // mul overflow while head pops
    sb.push_back(32'd4);
    wb_ack = 1'b1;
    #1;
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL pp_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL pp_head0 got %h want %h", wb_data, exp_v); end end
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    wb_ack = 1'b0;
    n_cmp++; if (rstatus_q !== 32'd4) begin n_err++; $display("FAIL pp_rs got %h want 4", rstatus_q); end
    tick();
    n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL pp_req got %b want 1", wb_req); end
    n_cmp++; if (wb_data !== sb[0]) begin n_err++; $display("FAIL pp_hold got %h want %h", wb_data, sb[0]); end
    wb_ack = 1'b1;
    #1;
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL pp_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL pp_head1 got %h want %h", wb_data, exp_v); end end
    tick();
    wb_ack = 1'b0;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL pp_drained got %b want 0", wb_req); end
  endtask

  // Event every cycle with ack held high: pointers wrap several times.
  task automatic test_back_to_back();
    wb_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'b10101, 5'd0, 0, 27'(100 + i));
      sb.push_back(32'(100 + i));
      #1;
      if (i > 0) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL b2b_sb_empty got %h want none", wb_data); end
        else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL b2b_%0d got %h want %h", i, wb_data, exp_v); end end
      end
      tick();
    end
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    n_cmp++;
    if (sb.size() == 0) begin n_err++; $display("FAIL b2b_sb_empty got %h want none", wb_data); end
    else begin exp_v = sb.pop_front(); if (wb_data !== exp_v) begin n_err++; $display("FAIL b2b_last got %h want %h", wb_data, exp_v); end end
    tick();
    wb_ack = 1'b0;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", wb_req); end
    n_cmp++; if (rstatus_q !== 32'd107) begin n_err++; $display("FAIL b2b_rs got %h want 6b", rstatus_q); end
  endtask

  task automatic test_reset_mid();
    wb_ack = 1'b0;
    drive(1, 5'b00000, 5'b00000, 1, 27'd0);
    tick();
    drive(1, 5'b00101, 5'd0, 1, 27'd0);
    tick();
    n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL rm_req_pre got %b want 1", wb_req); end
    drive(1, 5'b00000, 5'b00111, 1, 27'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_stall_pre got %b want 1", stall); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL rm_req got %b want 0", wb_req); end
    n_cmp++; if (rstatus_q !== 32'd0) begin n_err++; $display("FAIL rm_rs got %h want 0", rstatus_q); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_stall got %b want 0", stall); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL rm_wb_data got %h want 0", wb_data); end
    tick();
    drive(0, 5'd0, 5'd0, 0, 27'd0);
    reset = 1'b1;
    wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL rm_stale%0d got %b want 0", i, wb_req); end
    end
    wb_ack = 1'b0;
    n_cmp++; if (rstatus_q !== 32'd0) begin n_err++; $display("FAIL rm_rs_after got %h want 0", rstatus_q); end
  endtask

  initial begin
    test_reset();
    test_no_event();
    test_add_ovf();
    test_stall();
    test_setx();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
